// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand bus for the chunked sequential adder.
// The requester drives start/sub/a/b; the adder returns busy/done and the result.
interface seq_chunk_adder_if #(
    parameter int unsigned WIDTH = 17
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock with a carry register
// rippling between chunks. Reports carry-out and two's-complement overflow.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned CHUNK = 4
) (
    input logic              clk,
    input logic              rst,
    seq_chunk_adder_if.slave bus
);
    localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] chunk_sum;
    logic             chunk_carry;
    logic             last_chunk;
    int unsigned      lo;

    // Ripple only the bits of the current chunk; bits outside it keep their value.
    // The carry leaving the loop is the carry out of min(lo+CHUNK-1, WIDTH-1).
    always_comb begin
        lo          = CHUNK * 32'(idx_q);
        chunk_sum   = sum_q;
        chunk_carry = carry_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if ((32'(i) >= lo) && (32'(i) < lo + CHUNK)) begin
                chunk_sum[i] = opa_q[i] ^ opb_q[i] ^ chunk_carry;
                chunk_carry  = (opa_q[i] & opb_q[i]) | (chunk_carry & (opa_q[i] ^ opb_q[i]));
            end
        end
    end

    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert B here and seed the carry with sub.
                    opa_d   = bus.a;
                    opb_d   = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = chunk_sum;
                carry_d = chunk_carry;
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    idx_d   = '0;
                    cout_d  = chunk_carry;
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                              (chunk_sum[WIDTH-1] != opa_q[WIDTH-1]);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = done_q;
    assign bus.s    = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: three instances (17/4, 8/8, 17/1), stimulus
// pushes expected results with their due cycle, per-instance monitors pop on done.
module tb_seq_chunk_adder;
    typedef struct {
        logic [16:0] s;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    seq_chunk_adder_if #(.WIDTH(17)) bus0 ();
    seq_chunk_adder_if #(.WIDTH(8))  bus1 ();
    seq_chunk_adder_if #(.WIDTH(17)) bus2 ();

    seq_chunk_adder #(.WIDTH(17), .CHUNK(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_chunk_adder #(.WIDTH(17), .CHUNK(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [16:0] s, input logic c, input logic o, input int due);
        exp_t r;
        r.s    = s;
        r.cout = c;
        r.ovf  = o;
        r.cyc  = due;
        return r;
    endfunction

    // Reference for random vectors: full-width arithmetic, independent of chunking.
    function automatic exp_t model17(input logic [16:0] x, input logic [16:0] y, input logic sb,
                                     input int due);
        logic [16:0] yb;
        logic [17:0] f;
        yb = y ^ {17{sb}};
        f  = {1'b0, x} + {1'b0, yb} + 18'(sb);
        return mk(f[16:0], f[17], (x[16] == yb[16]) && (f[16] != x[16]), due);
    endfunction

    // Monitors: every done pulse must match the oldest expected entry, including its cycle.
    always @(negedge clk) begin
        if (bus0.done) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d0_spurious_done: got done=1 s=%0h want no done", bus0.s);
            end else begin
                e0 = q0.pop_front();
                check("d0_s", 32'(bus0.s), 32'(e0.s));
                check("d0_cout", 32'(bus0.cout), 32'(e0.cout));
                check("d0_ovf", 32'(bus0.ovf), 32'(e0.ovf));
                check("d0_latency", cyc, e0.cyc);
                check("d0_busy_with_done", 32'(bus0.busy), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.done) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d1_spurious_done: got done=1 s=%0h want no done", bus1.s);
            end else begin
                e1 = q1.pop_front();
                check("d1_s", 32'(bus1.s), 32'(e1.s));
                check("d1_cout", 32'(bus1.cout), 32'(e1.cout));
                check("d1_ovf", 32'(bus1.ovf), 32'(e1.ovf));
                check("d1_latency", cyc, e1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.done) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d2_spurious_done: got done=1 s=%0h want no done", bus2.s);
            end else begin
                e2 = q2.pop_front();
                check("d2_s", 32'(bus2.s), 32'(e2.s));
                check("d2_cout", 32'(bus2.cout), 32'(e2.cout));
                check("d2_ovf", 32'(bus2.ovf), 32'(e2.ovf));
                check("d2_latency", cyc, e2.cyc);
            end
        end
    end

    // Drive a one-cycle start on dut0; caller is at a negedge. Optionally push expectation.
    task automatic pulse0(input logic [16:0] a, input logic [16:0] b, input logic sb,
                          input logic push, input exp_t e);
        bus0.start = 1'b1;
        bus0.a     = a;
        bus0.b     = b;
        bus0.sub   = sb;
        if (push) q0.push_back(mk(e.s, e.cout, e.ovf, cyc + 1 + 5));
        @(negedge clk);
        bus0.start = 1'b0;
        bus0.a     = 17'h15A5A;
        bus0.b     = 17'h0A5A5;
        bus0.sub   = ~sb;
    endtask

    task automatic drain0();
        for (int i = 0; i < 100 && q0.size() != 0; i++) @(negedge clk);
        if (q0.size() != 0) begin
            total++;
            bad++;
            $display("FAIL d0_timeout: got %0d pending want 0", q0.size());
            q0.delete();
        end
        @(negedge clk);
    endtask

    task automatic run0(input logic [16:0] a, input logic [16:0] b, input logic sb,
                        input logic [16:0] s, input logic c, input logic o);
        pulse0(a, b, sb, 1'b1, mk(s, c, o, 0));
        drain0();
    endtask

    initial begin
        logic [16:0] ra, rb;
        logic        rs;
        total = 0;
        bad   = 0;
        bus0.start = 1'b0; bus0.sub = 1'b0; bus0.a = '0; bus0.b = '0;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
        bus2.start = 1'b0; bus2.sub = 1'b0; bus2.a = '0; bus2.b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_done", 32'(bus0.done), 32'd0);
        check("rst_s", 32'(bus0.s), 32'd0);
        check("rst_cout", 32'(bus0.cout), 32'd0);
        check("rst_ovf", 32'(bus0.ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed adds and subtracts, WIDTH=17 CHUNK=4.
        run0(17'h06667, 17'h18001, 1'b0, 17'h1E668, 1'b0, 1'b0);
        run0(17'h1FFFF, 17'h00001, 1'b0, 17'h00000, 1'b1, 1'b0);
        run0(17'h0FFFF, 17'h00001, 1'b0, 17'h10000, 1'b0, 1'b1);
        run0(17'h10000, 17'h10000, 1'b0, 17'h00000, 1'b1, 1'b1);
        run0(17'd5,     17'd7,     1'b1, 17'h1FFFE, 1'b0, 1'b0);
        run0(17'd7,     17'd5,     1'b1, 17'h00002, 1'b1, 1'b0);
        run0(17'h10000, 17'h00001, 1'b1, 17'h0FFFF, 1'b1, 1'b1);

        // Start while busy is ignored; start in the done cycle is accepted.
        pulse0(17'h00123, 17'h00456, 1'b0, 1'b1, mk(17'h00579, 1'b0, 1'b0, 0));
        pulse0(17'h1FFFF, 17'h1FFFF, 1'b1, 1'b0, mk(17'h0, 1'b0, 1'b0, 0));
        for (int i = 0; i < 20 && !bus0.done; i++) @(negedge clk);
        check("d0_done_seen", 32'(bus0.done), 32'd1);
        pulse0(17'h0FFFF, 17'h0FFFF, 1'b0, 1'b1, mk(17'h1FFFE, 1'b0, 1'b1, 0));
        drain0();

        // Reset two cycles into an operation abandons it without a done pulse.
        pulse0(17'h01111, 17'h02222, 1'b0, 1'b0, mk(17'h0, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus0.busy), 32'd0);
        check("abort_done", 32'(bus0.done), 32'd0);
        check("abort_s", 32'(bus0.s), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run0(17'h01111, 17'h02222, 1'b0, 17'h03333, 1'b0, 1'b0);

        // WIDTH=8 CHUNK=8: single-chunk operation.
        bus1.start = 1'b1; bus1.a = 8'hFF; bus1.b = 8'h01; bus1.sub = 1'b0;
        q1.push_back(mk(17'h0, 1'b1, 1'b0, cyc + 1 + 1));
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (4) @(negedge clk);
        check("d1_drained", 32'(q1.size()), 32'd0);

        // WIDTH=17 CHUNK=1: random operands against the full-width model.
        for (int k = 0; k < 6; k++) begin
            ra = 17'($urandom);
            rb = 17'($urandom);
            rs = 1'($urandom_range(1, 0));
            bus2.start = 1'b1; bus2.a = ra; bus2.b = rb; bus2.sub = rs;
            q2.push_back(model17(ra, rb, rs, cyc + 1 + 17));
            @(negedge clk);
            bus2.start = 1'b0;
            bus2.a = ~ra; bus2.b = ~rb; bus2.sub = ~rs;
            for (int i = 0; i < 40 && q2.size() != 0; i++) @(negedge clk);
            check("d2_drained", 32'(q2.size()), 32'd0);
            q2.delete();
            @(negedge clk);
        end

        check("d0_leftover", 32'(q0.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
